// File: rtl/pack_polyvec_seq_if.sv
// Signal bundle for the polyvec packing sequencer: control handshake,
// coefficient RAM read port, group-packer port and ciphertext byte RAM write port.
interface pack_polyvec_seq_if #(
    parameter int COEFF_W = 12
);
    logic                 clear;
    logic                 start;
    logic                 busy;
    logic                 done;

    logic                 coef_rd_en;
    logic [8:0]           coef_rd_addr;
    logic [COEFF_W-1:0]   coef_rd_data;

    logic                 grp_enable;
    logic [4*COEFF_W-1:0] grp_coeffs;
    logic                 grp_clear;
    logic                 grp_done;
    logic [39:0]          grp_ciphertext;

    logic                 ct_wr_en;
    logic [9:0]           ct_wr_addr;
    logic [7:0]           ct_wr_data;

    modport master (
        input  clear, start, coef_rd_data, grp_done, grp_ciphertext,
        output busy, done, coef_rd_en, coef_rd_addr, grp_enable, grp_coeffs,
               grp_clear, ct_wr_en, ct_wr_addr, ct_wr_data
    );

    modport slave (
        output clear, start, coef_rd_data, grp_done, grp_ciphertext,
        input  busy, done, coef_rd_en, coef_rd_addr, grp_enable, grp_coeffs,
               grp_clear, ct_wr_en, ct_wr_addr, ct_wr_data
    );
endinterface

// File: rtl/pack_polyvec_seq.sv
// Polyvec packing sequencer: reads coefficients four at a time, hands each group
// to an external group packer and writes the five returned bytes to ciphertext RAM.
module pack_polyvec_seq #(
    parameter int KYBER_K = 2,
    parameter int KYBER_N = 256,
    parameter int COEFF_W = 12
) (
    input  logic               clk,
    input  logic               reset_n,
    pack_polyvec_seq_if.master bus
);
    localparam int NUM_GRP = KYBER_K * KYBER_N / 4;
    localparam int GRP_W   = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1;
    localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(NUM_GRP - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        LAUNCH,
        WAIT_GRP,
        WR,
        FIN
    } seqState_e;

    seqState_e            state;
    seqState_e            stateNext;
    logic [GRP_W-1:0]     grpIdx;
    logic [2:0]           phaseCnt;
    logic [9:0]           byteAddr;
    logic [4*COEFF_W-1:0] coeffsQ;
    logic [39:0]          cipherQ;
    logic                 grpDonePrev;
    logic                 grpClearQ;
    logic                 grpDoneRise;
    logic                 phaseLast;
    logic                 rdEn;
    logic                 wrEn;
    logic                 grpEn;
    logic                 busyC;
    logic                 doneC;

    assign grpDoneRise = bus.grp_done & ~grpDonePrev;
    assign phaseLast   = (phaseCnt == 3'd4);

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // RD spans five cycles: four read strobes, then the cycle in which the
    // fourth coefficient returns and is captured.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case leaves a value unassigned and no latch is inferred.
        stateNext = state;
        busyC     = 1'b0;
        doneC     = 1'b0;
        rdEn      = 1'b0;
        grpEn     = 1'b0;
        wrEn      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) stateNext = RD;
            end
            RD: begin
                busyC = 1'b1;
                rdEn  = ~phaseLast;
                if (phaseLast) stateNext = LAUNCH;
            end
            LAUNCH: begin
                busyC = 1'b1;
                // Hold off the launch while a stale completion is still visible.
                if (!bus.grp_done) begin
                    grpEn     = 1'b1;
                    stateNext = WAIT_GRP;
                end
            end
            WAIT_GRP: begin
                busyC = 1'b1;
                if (grpDoneRise) stateNext = WR;
            end
            WR: begin
                busyC = 1'b1;
                wrEn  = 1'b1;
                if (phaseLast) stateNext = (grpIdx == LAST_GRP) ? FIN : RD;
            end
            FIN: begin
                doneC     = ~bus.clear;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
        if (bus.clear) stateNext = IDLE;
    end

    // NOTE: the coefficient and ciphertext holding registers are reset as well,
    // because they drive outputs that must read zero during reset and after clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grpIdx      <= '0;
            phaseCnt    <= '0;
            byteAddr    <= '0;
            coeffsQ     <= '0;
            cipherQ     <= '0;
            grpDonePrev <= 1'b0;
            grpClearQ   <= 1'b0;
        end else begin
            grpDonePrev <= bus.grp_done;
            grpClearQ   <= bus.clear;
            if (bus.clear) begin
                grpIdx   <= '0;
                phaseCnt <= '0;
                byteAddr <= '0;
                coeffsQ  <= '0;
                cipherQ  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            grpIdx   <= '0;
                            phaseCnt <= '0;
                            byteAddr <= '0;
                        end
                    end
                    RD: begin
                        // Data for read n arrives while phaseCnt = n+1; slot 0 is the MSBs.
                        if (phaseCnt != 3'd0) begin
                            coeffsQ[(4 - int'(phaseCnt)) * COEFF_W +: COEFF_W] <= bus.coef_rd_data;
                        end
                        phaseCnt <= phaseLast ? 3'd0 : phaseCnt + 3'd1;
                    end
                    WAIT_GRP: begin
                        if (grpDoneRise) cipherQ <= bus.grp_ciphertext;
                    end
                    WR: begin
                        byteAddr <= byteAddr + 10'd1;
                        phaseCnt <= phaseLast ? 3'd0 : phaseCnt + 3'd1;
                        if (phaseLast && grpIdx != LAST_GRP) grpIdx <= grpIdx + GRP_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.busy         = busyC;
    assign bus.done         = doneC;
    assign bus.coef_rd_en   = rdEn;
    assign bus.coef_rd_addr = rdEn ? 9'({grpIdx, phaseCnt[1:0]}) : 9'd0;
    assign bus.grp_enable   = grpEn;
    assign bus.grp_coeffs   = coeffsQ;
    assign bus.grp_clear    = grpClearQ;
    assign bus.ct_wr_en     = wrEn;
    assign bus.ct_wr_addr   = wrEn ? byteAddr : 10'd0;
    assign bus.ct_wr_data   = wrEn ? cipherQ[39 - 8 * int'(phaseCnt) -: 8] : 8'd0;
endmodule

// File: doc/pack_polyvec_seq.md
PACK_POLYVEC_SEQ -- requirements
Module: pack_polyvec_seq

Interface
REQ-001 Parameter KYBER_K, default 2: number of polynomials in the vector.
REQ-002 Parameter KYBER_N, default 256: coefficients per polynomial.
REQ-003 Parameter COEFF_W, default 12: coefficient width in bits.
REQ-004 clk  in  1  clock; all logic samples on the rising edge.
REQ-005 reset_n  in  1  reset, asynchronous, active-low.
REQ-006 clear  in  1  synchronous abort; forces IDLE.
REQ-007 start  in  1  single-cycle request to pack the whole polyvec.
REQ-008 busy  out  1  high from the cycle after an accepted start until done.
REQ-009 done  out  1  one-cycle pulse when the last byte has been written.
REQ-010 coef_rd_en  out  1  coefficient RAM read strobe.
REQ-011 coef_rd_addr  out  9  coefficient index, 0..KYBER_K*KYBER_N-1.
REQ-012 coef_rd_data  in  COEFF_W  read data; valid exactly 1 cycle after coef_rd_en.
REQ-013 grp_enable  out  1  one-cycle launch pulse to the group packer.
REQ-014 grp_coeffs  out  4*COEFF_W  four coefficients; coeff 0 in [47:36], coeff 3 in [11:0].
REQ-015 grp_clear  out  1  one-cycle clear to the group packer.
REQ-016 grp_done  in  1  group packer completion flag; may stay high more than one cycle.
REQ-017 grp_ciphertext  in  40  5 packed bytes from the group packer.
REQ-018 ct_wr_en  out  1  ciphertext byte RAM write strobe.
REQ-019 ct_wr_addr  out  10  byte address, 0..639 at defaults.
REQ-020 ct_wr_data  out  8  byte written.

Function
REQ-021 States SHALL be IDLE, RD, LAUNCH, WAIT_GRP, WR, FIN.
REQ-022 IDLE: start=1 -> RD, group counter g=0; start while not IDLE SHALL be ignored.
REQ-023 RD: coef_rd_en high for 4 consecutive cycles, addresses 4g+0..4g+3.
REQ-024 Each returned coefficient j SHALL be captured into grp_coeffs slot j one cycle after its read.
REQ-025 LAUNCH SHALL be entered the cycle after the 4th capture; grp_enable=1 for exactly that cycle.
REQ-026 grp_coeffs SHALL hold stable from LAUNCH until grp_done is detected.
REQ-027 WAIT_GRP SHALL exit on the grp_done rising edge (grp_done=1 with previous-cycle value 0), latching grp_ciphertext in the same cycle.
REQ-028 WR: 5 consecutive cycles with ct_wr_en=1, byte k = latched[39-8k -: 8], address 5g+k.
REQ-029 After WR: if g = KYBER_K*KYBER_N/4-1 (127), go to FIN; else increment g and go to RD.
REQ-030 FIN: done=1 for one cycle, busy=0 in the same cycle, then IDLE.
REQ-031 grp_enable SHALL never assert while grp_done=1.
REQ-032 Per-group latency, excluding the group packer: 4 RD + 1 capture + 1 LAUNCH + 5 WR cycles.
REQ-033 Counters SHALL NOT wrap: g ranges 0..127 and byte address 0..639 at defaults.
REQ-034 clear=1 in any state SHALL force IDLE next cycle, zero the counters and outputs, and pulse grp_clear; no done pulse is produced.
REQ-035 clear and start in the same cycle: clear wins and start is dropped.

Reset
REQ-036 With reset_n=0, all outputs SHALL be 0 (busy, done, strobes, addresses, data, grp_coeffs, grp_enable, grp_clear), the state SHALL be IDLE and the counters 0.
REQ-037 Reset mid-operation SHALL abandon the run with no further writes; a new start after reset restarts from g=0.

Verification
REQ-038 RAM coef[i]=i mod 3329, start -> 512 reads in order, 128 grp_enable pulses, 640 writes at addresses 0..639, one done pulse.
REQ-039 Group model returns 40'h0102030405 -> bytes 01,02,03,04,05 at addresses 5g..5g+4.
REQ-040 Coefficients 0xABC,0x123,0x456,0x789 at g=0 -> grp_coeffs=48'hABC123456789 at LAUNCH, stable until grp_done.
REQ-041 grp_done held high for 3 cycles -> exactly one latch and one WR burst; no grp_enable while grp_done=1.
REQ-042 clear asserted during WR of g=5 -> IDLE next cycle, grp_clear pulse, no done; restart completes all 640 bytes.
REQ-043 start pulsed while busy, and reset_n low at g=60 -> start ignored; after reset all outputs are 0 and IDLE.
